match_seq_ctrl: RTL and testbench

//  Multi-cycle controller for the EX-stage byte-match operation (op_match).

---
 rtl/match_seq_if.sv | 32 +++
 rtl/match_seq_ctrl.sv | 136 +++++++++++++
 tb/tb_match_seq_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/match_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : match_seq_if
//  Purpose  : EX-stage <-> byte-match controller handshake bundle.
//             master = EX stage (issues op, consumes stall/result)
//             slave  = match_seq_ctrl
//  Signals  : flush, start, src1, src2        (master -> slave)
//             stallreq, result_valid, result  (slave  -> master)
//  Revision : 1.0 - initial release
// ============================================================================
interface match_seq_if #(
  parameter int WIDTH = 32
) ();
  logic             flush;
  logic             start;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             stallreq;
  logic             result_valid;
  logic [WIDTH-1:0] result;

  modport master (
    output flush, start, src1, src2,
    input  stallreq, result_valid, result
  );

  modport slave (
    input  flush, start, src1, src2,
    output stallreq, result_valid, result
  );
endinterface
`default_nettype wire

// File: rtl/match_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : match_seq_ctrl
//  Purpose  : Multi-cycle byte-match controller. Finds the lowest bit offset
//             of src2 where a WIN-bit window equals src1[WIN-1:0], testing
//             STEP offsets per cycle and stalling the pipeline meanwhile.
//  Ports    : clk  - clock, rising edge
//             rst  - asynchronous active-high reset
//             ex   - match_seq_if.slave (flush/start/src1/src2 in,
//                    stallreq/result_valid/result out)
//  Revision : 1.0 - initial release
// ============================================================================
module match_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int WIN   = 8,
  parameter int STEP  = 1
) (
  input  wire logic   clk,
  input  wire logic   rst,
  match_seq_if.slave  ex
);

  localparam int POSITIONS = WIDTH - WIN + 1;
  localparam int PW        = $clog2(POSITIONS) + 1;  // pos width
  localparam int IW        = $clog2(WIDTH);          // bit-index width

  // Offsets are summed one bit wider than pos so pos+k can never wrap.
  localparam logic [PW:0] C_POS_LIM = (PW+1)'(POSITIONS);
  localparam logic [PW:0] C_STEP_W  = (PW+1)'(STEP);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    pos_q,   pos_d;
  logic [WIN-1:0]   pat_q,   pat_d;
  logic [WIDTH-1:0] word_q,  word_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [STEP-1:0]  w_hit;
  logic             w_any;
  logic [PW-1:0]    w_first;
  logic             w_last;
  logic [PW-1:0]    w_hit_pos;

  // Only the low WIN bits of src1 carry the pattern.
  logic w_unused_src1;
  assign w_unused_src1 = ^ex.src1[WIDTH-1:WIN];

  // One comparator per offset tested this cycle; offsets past the last
  // legal window are masked so the out-of-range part-select never counts.
  for (genvar k = 0; k < STEP; k++) begin : g_win
    logic [PW:0] w_off;
    assign w_off    = {1'b0, pos_q} + (PW+1)'(k);
    assign w_hit[k] = (w_off < C_POS_LIM) &&
                      (word_q[w_off[IW-1:0] +: WIN] == pat_q);
  end

  // Lowest hitting k wins: scan downward so the smallest overwrites last.
  always_comb begin
    w_any   = 1'b0;
    w_first = '0;
    for (int k = STEP - 1; k >= 0; k--) begin
      if (w_hit[k]) begin
        w_any   = 1'b1;
        w_first = PW'(k);
      end
    end
  end

  assign w_last    = ({1'b0, pos_q} + C_STEP_W) >= C_POS_LIM;
  assign w_hit_pos = pos_q + w_first;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pos_q    <= '0;
      pat_q    <= '0;
      word_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      pat_q    <= pat_d;
      word_q   <= word_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    pat_d    = pat_q;
    word_d   = word_q;
    result_d = result_q;
    if (ex.flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (ex.start) begin
            pat_d   = ex.src1[WIN-1:0];
            word_d  = ex.src2;
            pos_d   = '0;
            state_d = S_SCAN;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_SCAN: begin
          if (w_any) begin
            result_d = {{(WIDTH-PW){1'b0}}, w_hit_pos};
            state_d  = S_DONE;
          end else if (w_last) begin
            result_d = '1;
            state_d  = S_DONE;
          end else begin
            pos_d    = pos_q + C_STEP_W[PW-1:0];
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Stall is released in DONE so the instruction leaves EX with its result.
  assign ex.stallreq     = ~rst & ((ex.start & (state_q != S_SCAN) & ~ex.flush) |
                                   (state_q == S_SCAN));
  assign ex.result_valid = (state_q == S_DONE);
  assign ex.result       = result_q;

endmodule
`default_nettype wire

// File: tb/tb_match_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_match_seq_ctrl
//  Purpose  : Directed self-checking bench for match_seq_ctrl, with one
//             STEP=1 instance and one STEP=4 instance.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_match_seq_ctrl;

  logic clk;
  logic rst;

  match_seq_if #(.WIDTH(32)) if1 ();
  match_seq_if #(.WIDTH(32)) if4 ();

  match_seq_ctrl #(.WIDTH(32), .WIN(8), .STEP(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .ex  (if1)
  );

  match_seq_ctrl #(.WIDTH(32), .WIN(8), .STEP(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .ex  (if4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic st, input logic [7:0] pat,
                       input logic [31:0] word);
    if (sel) begin
      if4.start = st; if4.src1 = {24'h0, pat}; if4.src2 = word;
    end else begin
      if1.start = st; if1.src1 = {24'h0, pat}; if1.src2 = word;
    end
  endtask

  task automatic set_start(input bit sel, input logic st);
    if (sel) if4.start = st;
    else     if1.start = st;
  endtask

  function automatic logic get_stall(input bit sel);
    return sel ? if4.stallreq : if1.stallreq;
  endfunction

  function automatic logic get_valid(input bit sel);
    return sel ? if4.result_valid : if1.result_valid;
  endfunction

  function automatic logic [31:0] get_result(input bit sel);
    return sel ? if4.result : if1.result;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issues one op in the current cycle (cycle 0), holds start while the
  // pipeline is stalled, drops it in the expected DONE cycle.
  task automatic run_op(input string tag, input bit sel, input logic [7:0] pat,
                        input logic [31:0] word, input logic [31:0] exp_res,
                        input int exp_cyc);
    int          vcyc;
    int          stall_n;
    int          vwidth;
    logic [31:0] res;
    vcyc = -1; stall_n = 0; vwidth = 0; res = ~exp_res;
    drive(sel, 1'b1, pat, word);
    for (int c = 0; c <= exp_cyc + 3; c++) begin
      if (c == exp_cyc) set_start(sel, 1'b0);
      @(negedge clk);
      if (get_stall(sel)) stall_n++;
      if (get_valid(sel)) begin
        if (vcyc < 0) begin
          vcyc = c;
          res  = get_result(sel);
        end
        vwidth++;
      end
      next_cycle();
    end
    check({tag, "_lat"},   32'(vcyc),    32'(exp_cyc));
    check({tag, "_res"},   res,          exp_res);
    check({tag, "_stall"}, 32'(stall_n), 32'(exp_cyc));
    check({tag, "_vw"},    32'(vwidth),  32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          vcnt;
    logic [6:0]  vpat;
    logic [6:0]  spat;
    logic [31:0] res2;
    logic [31:0] res4;

    rst = 1'b1;
    if1.flush = 1'b0; if1.start = 1'b0; if1.src1 = '0; if1.src2 = '0;
    if4.flush = 1'b0; if4.start = 1'b0; if4.src1 = '0; if4.src2 = '0;
    #12;
    check("rst_stall",  32'(if1.stallreq),     32'd0);
    check("rst_valid",  32'(if1.result_valid), 32'd0);
    check("rst_result", if1.result,            32'd0);
    @(negedge clk);
    rst = 1'b0;
    next_cycle();

    // Basic hit, overlap (lowest wins), last offset, no match
    run_op("t1",  1'b0, 8'hFF, 32'h0000_3FC0, 32'd6,         8);
    run_op("t3",  1'b0, 8'hFF, 32'h0000_FFFF, 32'd0,         2);
    run_op("t2a", 1'b0, 8'hFF, 32'hFF00_0000, 32'd24,        26);
    run_op("t2b", 1'b0, 8'h01, 32'h0000_0000, 32'hFFFF_FFFF, 26);

    // Flush in cycle 5 of a long scan
    drive(1'b0, 1'b1, 8'hFF, 32'hFF00_0000);
    repeat (5) next_cycle();
    if1.flush = 1'b1;
    @(negedge clk);
    check("t5_stall_c5", 32'(if1.stallreq), 32'd1);
    next_cycle();
    if1.flush = 1'b0;
    if1.start = 1'b0;
    @(negedge clk);
    check("t5_stall_c6", 32'(if1.stallreq), 32'd0);
    vcnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (if1.result_valid) vcnt++;
    end
    check("t5_novalid", 32'(vcnt),  32'd0);
    check("t5_res_kept", if1.result, 32'hFFFF_FFFF);
    next_cycle();

    // Flush and start together: nothing latched
    drive(1'b0, 1'b1, 8'hFF, 32'h0000_00FF);
    if1.flush = 1'b1;
    @(negedge clk);
    check("fs_stall", 32'(if1.stallreq), 32'd0);
    next_cycle();
    if1.flush = 1'b0;
    if1.start = 1'b0;
    vcnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (if1.result_valid) vcnt++;
    end
    check("fs_novalid", 32'(vcnt),  32'd0);
    check("fs_res_kept", if1.result, 32'hFFFF_FFFF);
    next_cycle();

    // Back-to-back: second start accepted in the DONE cycle of the first
    vpat = '0; spat = '0; res2 = '1; res4 = '1;
    drive(1'b0, 1'b1, 8'hFF, 32'h0000_FFFF);
    for (int c = 0; c < 7; c++) begin
      if (c == 2) drive(1'b0, 1'b1, 8'hFF, 32'h0000_00FF);
      if (c == 4) set_start(1'b0, 1'b0);
      @(negedge clk);
      vpat[c] = if1.result_valid;
      spat[c] = if1.stallreq;
      if (c == 2) res2 = if1.result;
      if (c == 4) res4 = if1.result;
      next_cycle();
    end
    check("t6_valid_pat", 32'(vpat), 32'b0010100);
    check("t6_stall_pat", 32'(spat), 32'b0001111);
    check("t6_res_first", res2,      32'd0);
    check("t6_res_second", res4,     32'd0);

    run_op("t1b", 1'b0, 8'hFF, 32'h0000_3FC0, 32'd6, 8);

    // STEP=4 instance
    run_op("t4",   1'b1, 8'hFF, 32'hFF00_0000, 32'd24,        8);
    run_op("t4nm", 1'b1, 8'h01, 32'h0000_0000, 32'hFFFF_FFFF, 8);
    run_op("t4b",  1'b1, 8'hFF, 32'h0000_3FC0, 32'd6,         3);

    // Asynchronous reset in the middle of a scan, between clock edges
    drive(1'b0, 1'b1, 8'hFF, 32'hFF00_0000);
    repeat (10) next_cycle();
    #1;
    rst = 1'b1;
    #1;
    check("arst_stall",   32'(if1.stallreq),     32'd0);
    check("arst_valid",   32'(if1.result_valid), 32'd0);
    check("arst_result",  if1.result,            32'd0);
    check("arst_result4", if4.result,            32'd0);
    if1.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    next_cycle();
    vcnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (if1.result_valid) vcnt++;
    end
    check("arst_novalid", 32'(vcnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
